// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: EX-stage <-> MDU controller bundle.
//   master (EX side) drives: start, mdu_op, flush, src_a, src_b, mdu_use, hi_sel
//   slave  (MDU side) drives: busy, stall, mdu_result
// Handshake: an instruction is taken when start & ~flush & ~busy and the
// controller is idle. While busy, EX must hold the MDU instruction (stall
// tells the hazard unit to do so) and re-present it once busy falls.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  mdu_op;
  logic        flush;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mdu_use;
  logic        hi_sel;
  logic        busy;
  logic        stall;
  logic [31:0] mdu_result;

  modport master (
    output start, mdu_op, flush, src_a, src_b, mdu_use, hi_sel,
    input  busy, stall, mdu_result
  );

  modport slave (
    input  start, mdu_op, flush, src_a, src_b, mdu_use, hi_sel,
    output busy, stall, mdu_result
  );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide controller holding the HI/LO pair.
// The result is computed at the accept edge and held in a pending register;
// a countdown FSM models the iterative latency and commits HI/LO when it ends.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   bus         mdu_ctrl_if.slave (start/op/operands in, busy/stall/result out)
//   dbg_state   current FSM state (0 idle, 1 run)
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  mdu_ctrl_if.slave     bus,
  output logic          dbg_state
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   pend_hi_q, pend_lo_q;
  logic          pend_wr_q;

  logic          is_long;
  logic          accept;
  logic [31:0]   res_hi, res_lo;
  logic          res_wr;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   div_b;
  logic          div_ovf;

  assign is_long = (bus.mdu_op >= OP_MULT) && (bus.mdu_op <= OP_DIVU);
  assign accept  = bus.start & ~bus.flush & (state_q == IDLE);

  assign bus.busy       = (state_q == RUN);
  assign bus.stall      = bus.mdu_use & (bus.busy | (bus.start & (state_q == IDLE) & is_long));
  assign bus.mdu_result = bus.hi_sel ? hi_q : lo_q;
  assign dbg_state      = state_q;

  // Operand arithmetic. The divisor is forced non-zero so the divider never
  // sees zero; a zero divisor instead clears res_wr so HI/LO stay untouched.
  assign prod_s  = $signed({{32{bus.src_a[31]}}, bus.src_a}) *
                   $signed({{32{bus.src_b[31]}}, bus.src_b});
  assign prod_u  = {32'b0, bus.src_a} * {32'b0, bus.src_b};
  assign div_b   = (bus.src_b == 32'd0) ? 32'd1 : bus.src_b;
  assign div_ovf = (bus.src_a == 32'h8000_0000) && (bus.src_b == 32'hFFFF_FFFF);

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b1;
    case (bus.mdu_op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (bus.src_b == 32'd0) begin
          res_wr = 1'b0;
        end else if (div_ovf) begin
          // Most-negative / -1 overflows; the quotient wraps to itself.
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else begin
          res_lo = $signed(bus.src_a) / $signed(div_b);
          res_hi = $signed(bus.src_a) % $signed(div_b);
        end
      end
      OP_DIVU: begin
        res_wr = (bus.src_b != 32'd0);
        res_lo = bus.src_a / div_b;
        res_hi = bus.src_a % div_b;
      end
      default: res_wr = 1'b0;
    endcase
  end

  // FSM next-state / countdown
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (accept && is_long) begin
          state_d = RUN;
          count_d = ((bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU)) ?
                    CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end
      end
      RUN: begin
        if (count_q == CW'(1)) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Pending result and architectural HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (accept && is_long) begin
        pend_hi_q <= res_hi;
        pend_lo_q <= res_lo;
        pend_wr_q <= res_wr;
      end
      if (accept && (bus.mdu_op == OP_MTHI)) hi_q <= bus.src_a;
      if (accept && (bus.mdu_op == OP_MTLO)) lo_q <= bus.src_a;
      if ((state_q == RUN) && (count_q == CW'(1)) && pend_wr_q) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end
    end
  end
endmodule
